dpi_txn_collector: RTL
======================

Name: dpi_txn_collector

Overview:
- Parametrised multi-channel successor to the per-CPU DPI polling top.
- Accepts CH_NB independent valid/ready streams of DATA_W-bit words, one per CPU server poller.
- Buffers each channel in its own FIFO and merges all channels round-robin into one tagged output stream.
- Counts delivered transactions per channel and flags per-channel and global completion, which the testbench uses to end simulation.

Parameters:
- CH_NB, 4, number of input channels (1..16).
- DATA_W, 64, data word width.
- FIFO_DEPTH, 4, per-channel FIFO depth; a power of 2, at least 2.
- TXN_NB, 1000, delivered transactions per channel that mark the channel done.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_vld  in  CH_NB  per-channel input valid.
- in_data  in  CH_NB*DATA_W  per-channel input data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_rdy  out  CH_NB  per-channel input ready; high when that channel's FIFO is not full.
- out_vld  out  1  merged output valid.
- out_data  out  DATA_W  merged output data.
- out_ch  out  $clog2(CH_NB) (min 1)  source channel index of out_data.
- out_rdy  in  1  downstream ready.
- txn_done  out  CH_NB  per-channel sticky done flag.
- all_done  out  1  high when every bit of txn_done is set.

Behaviour:
- Reset (asynchronous assertion, synchronous release):
  - All FIFOs empty, so in_rdy = all ones and out_vld = 0.
  - out_data = 0 and out_ch = 0.
  - rr_ptr = 0, lock = 0, all counters = 0, txn_done = 0, all_done = 0.
  - Reset mid-operation discards all buffered data and counts.
- Input push:
  - Channel i pushes when in_vld[i] && in_rdy[i].
  - in_rdy[i] = !full[i]. It is a combinational function of registered occupancy only and never depends on in_vld.
- FIFO:
  - Registered occupancy; a word pushed in cycle N is visible at its FIFO head in cycle N+1.
  - Push and pop in the same cycle on a non-empty FIFO leave occupancy unchanged.
  - A full FIFO cannot push, even if it pops that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Arbitration:
  - Grant goes to the first non-empty channel searching from rr_ptr upward, wrapping modulo CH_NB.
  - out_vld = any FIFO non-empty; out_data and out_ch come from the granted FIFO head.
- Stability:
  - When out_vld && !out_rdy, the grant is latched (lock = 1, locked index registered).
  - out_ch and out_data stay unchanged until the handshake, even if higher-priority channels become non-empty.
  - lock clears on handshake.
- Handshake (out_vld && out_rdy):
  - Pop the granted FIFO.
  - rr_ptr <= (grant + 1) mod CH_NB.
  - The delivering channel's counter increments.
- Counters:
  - Width $clog2(TXN_NB+1); saturate at TXN_NB.
  - A channel keeps accepting and delivering data after done; its counter does not wrap.
- txn_done[i]:
  - Set in the cycle after the handshake that brings counter i to TXN_NB.
  - Sticky until reset.
- all_done: registered, equals &txn_done delayed by one cycle.
- Latency:
  - Minimum input-to-output latency is 1 cycle with an empty design and out_rdy high.
  - Sustained throughput is one word per cycle total across all channels.
- CH_NB = 1: arbitration degenerates and out_ch is always 0.
- Unknown or X on in_data of an unpushed channel must not propagate into any FIFO.

Test Plan:
- Reset then idle:
  - Stimulus: hold in_vld = 0 for 10 cycles.
  - Required: in_rdy = 4'b1111, out_vld = 0, txn_done = 0, all_done = 0 throughout.
- Single-channel latency:
  - Stimulus: push 0xDEADBEEF_00000001 on ch2 at cycle N, out_rdy = 1.
  - Required: out_vld = 1, out_ch = 2, out_data = 0xDEADBEEF_00000001 at cycle N+1; out_vld = 0 at N+2.
- Round-robin fairness:
  - Stimulus: all 4 channels continuously valid, out_rdy = 1.
  - Required: out_ch sequence 0,1,2,3,0,1,... with no channel skipped for 40 cycles.
- Backpressure and stability:
  - Stimulus: out_rdy = 0 while ch0 holds 0x10 and ch1 later fills; then release.
  - Required: in_rdy[0] = 0 after 4 pushes; out_ch = 0, out_data = 0x10 held stable; after release, all 4 ch0 words delivered in order with none lost.
- Completion:
  - Stimulus: TXN_NB = 8, ch0..ch3 each send 8 words at random rates with random out_rdy.
  - Required: txn_done bits each rise one cycle after that channel's 8th handshake; all_done rises one cycle after the last bit; further words on a done channel still delivered with its counter held at 8.
- Asynchronous reset mid-stream:
  - Stimulus: drop rst_n between edges while FIFOs are partially full.
  - Required: out_vld = 0 and in_rdy = all ones immediately; counters = 0; post-release traffic starts from rr_ptr = 0.

Source files
------------

// File: rtl/dpi_txn_collector.sv
// Multi-channel transaction collector: per-channel FIFOs merged round-robin into
// one tagged output stream, with saturating per-channel delivery counters and done flags.
module dpi_txn_collector #(
  parameter int CH_NB      = 4,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int TXN_NB     = 1000,
  localparam int CH_W      = (CH_NB > 1) ? $clog2(CH_NB) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CH_NB-1:0]        in_vld,
  input  logic [CH_NB*DATA_W-1:0] in_data,
  output logic [CH_NB-1:0]        in_rdy,
  output logic                    out_vld,
  output logic [DATA_W-1:0]       out_data,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_rdy,
  output logic [CH_NB-1:0]        txn_done,
  output logic                    all_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TXN_NB + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_W'(TXN_NB)) return CNT_W'(TXN_NB);
    else return v + 1'b1;
  endfunction

  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] v);
    return CH_W'((int'(v) + 1) % CH_NB);
  endfunction

  logic [CH_NB-1:0]  full;
  logic [CH_NB-1:0]  empty;
  logic [CH_NB-1:0]  push;
  logic [CH_NB-1:0]  pop;
  logic [DATA_W-1:0] head [CH_NB];

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_grant;
  logic [CH_W-1:0]   lock_idx;
  logic              lock;
  logic [CH_W-1:0]   grant;
  logic              hs;
  logic [DATA_W-1:0] head_sel;
  logic [CNT_W-1:0]  cnt [CH_NB];

  // Input stage: one FIFO per channel; storage is written only on an accepted push
  for (genvar i = 0; i < CH_NB; i++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    assign full[i]  = (occ == OCC_W'(FIFO_DEPTH));
    assign empty[i] = (occ == '0);
    assign in_rdy[i] = ~full[i];
    assign push[i]  = in_vld[i] & ~full[i];
    assign pop[i]   = hs & (grant == CH_W'(i));
    assign head[i]  = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= in_data[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        if (push[i] && !pop[i])      occ <= occ + 1'b1;
        else if (!push[i] && pop[i]) occ <= occ - 1'b1;
      end
    end
  end

  // Arbitration stage: first non-empty channel at or after rr_ptr, unless a stalled grant is held
  always_comb begin
    int  idx;
    logic found;
    rr_grant = '0;
    found    = 1'b0;
    for (int k = 0; k < CH_NB; k++) begin
      idx = (int'(rr_ptr) + k) % CH_NB;
      if (!found && !empty[idx]) begin
        rr_grant = CH_W'(idx);
        found    = 1'b1;
      end
    end
  end

  assign grant   = lock ? lock_idx : rr_grant;
  assign out_vld = ~&empty;
  assign hs      = out_vld & out_rdy;

  always_comb begin
    head_sel = '0;
    for (int i = 0; i < CH_NB; i++) begin
      if (grant == CH_W'(i)) head_sel = head[i];
    end
  end

  // Empty FIFO heads are undefined storage, so the output is forced to zero when idle
  assign out_data = out_vld ? head_sel : '0;
  assign out_ch   = out_vld ? grant : '0;

  // Control stage: round-robin pointer, stall lock, delivery counters and completion flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      txn_done <= '0;
      all_done <= 1'b0;
      for (int i = 0; i < CH_NB; i++) cnt[i] <= '0;
    end else begin
      all_done <= &txn_done;
      if (hs) begin
        rr_ptr <= wrap_inc(grant);
        lock   <= 1'b0;
        for (int i = 0; i < CH_NB; i++) begin
          if (grant == CH_W'(i)) begin
            cnt[i] <= sat_inc(cnt[i]);
            if (cnt[i] == CNT_W'(TXN_NB - 1)) txn_done[i] <= 1'b1;
          end
        end
      end else if (out_vld) begin
        lock     <= 1'b1;
        lock_idx <= grant;
      end
    end
  end

endmodule
